// File: rtl/bip_debug_unit_if.sv
// Interface bundling the UART byte link, CPU control and data-memory debug port
// of the BIP debug sequencer. The debug unit connects through the master modport;
// the UART, CPU and data memory side connects through the slave modport.
//
// Handshake semantics (one rule for every strobe here): rx_done, tx_start and
// tx_done are single-cycle pulses that qualify the data sampled in that same
// cycle. There is no back-pressure. A new tx_start is issued only after the
// tx_done of the previous byte. dm_rd is answered by dm_data one cycle later.
interface bip_debug_unit_if #(
    parameter int AB = 11,
    parameter int DB = 16
);
    logic [7:0]    rx_data;
    logic          rx_done;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;
    logic          cpu_en;
    logic          halt;
    logic [AB-1:0] pc;
    logic [DB-1:0] acc;
    logic          dbg_own;
    logic [AB-1:0] dm_addr;
    logic          dm_rd;
    logic [DB-1:0] dm_data;

    modport master (
        input  rx_data, rx_done, tx_done, halt, pc, acc, dm_data,
        output tx_data, tx_start, cpu_en, dbg_own, dm_addr, dm_rd
    );

    modport slave (
        output rx_data, rx_done, tx_done, halt, pc, acc, dm_data,
        input  tx_data, tx_start, cpu_en, dbg_own, dm_addr, dm_rd
    );
endinterface

// File: rtl/bip_debug_unit.sv
// UART-driven debug sequencer for the BIP accumulator CPU.
// It gates CPU execution with cpu_en through three commands:
//   'R' runs until halt.
//   'S' executes a single step.
//   'D' dumps only, with no execution.
// After each command it owns the data-memory read port and streams a status frame:
//   CNT, PC, ACC, then MEM[0..DUMP_DEPTH-1], each field big-endian.
// Optional macro DBG_CHECKSUM_EN appends an XOR checksum byte to the frame.
module bip_debug_unit #(
    parameter int AB         = 11,
    parameter int DB         = 16,
    parameter int DUMP_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    bip_debug_unit_if.master   bus,
    output logic [2:0]         dbg_state_o
);
    localparam int HDR_LEN = 6;
    localparam int MEM_END = HDR_LEN + 2 * DUMP_DEPTH;
`ifdef DBG_CHECKSUM_EN
    localparam int FRAME_LEN = MEM_END + 1;
`else
    localparam int FRAME_LEN = MEM_END;
`endif
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam logic [BW-1:0] HDR_B = BW'(HDR_LEN);
    localparam logic [BW-1:0] MEM_B = BW'(MEM_END);
    localparam logic [BW-1:0] LEN_B = BW'(FRAME_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_STEP, S_LATCH, S_SEND, S_WAIT, S_MEMRD, S_MEMCAP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [47:0]   hdr_q, hdr_d;
    logic [15:0]   word_q, word_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [AB-1:0] word_idx_q, word_idx_d;
    logic          cpu_en_q, cpu_en_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          dm_rd_q, dm_rd_d;
    logic [AB-1:0] dm_addr_q, dm_addr_d;
    logic          dbg_own_q, dbg_own_d;
    logic [7:0]    cur_byte;
    logic          in_mem;
`ifdef DBG_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    // Byte index inside the memory section. An odd index is the low byte of a word.
    assign in_mem = (byte_idx_q >= HDR_B) && (byte_idx_q < MEM_B);

    // Select the frame byte addressed by byte_idx_q.
    always_comb begin
        cur_byte = 8'h00;
        if (byte_idx_q < HDR_B) begin
            case (byte_idx_q[2:0])
                3'd0:    cur_byte = hdr_q[47:40];
                3'd1:    cur_byte = hdr_q[39:32];
                3'd2:    cur_byte = hdr_q[31:24];
                3'd3:    cur_byte = hdr_q[23:16];
                3'd4:    cur_byte = hdr_q[15:8];
                default: cur_byte = hdr_q[7:0];
            endcase
        end else if (in_mem) begin
            cur_byte = byte_idx_q[0] ? word_q[7:0] : word_q[15:8];
        end
`ifdef DBG_CHECKSUM_EN
        else begin
            cur_byte = csum_q;
        end
`endif
    end

    // Cycle counter: counts enabled CPU cycles, saturating at 0xFFFF.
    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        cpu_en_d   = 1'b0;
        dbg_own_d  = dbg_own_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        dm_rd_d    = 1'b0;
        dm_addr_d  = '0;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        hdr_d      = hdr_q;
        word_d     = word_q;
`ifdef DBG_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.rx_done) begin
                    case (bus.rx_data)
                        8'h52: begin
                            if (bus.halt) begin
                                state_d = S_LATCH;
                            end else begin
                                state_d  = S_RUN;
                                cpu_en_d = 1'b1;
                            end
                        end
                        8'h53: begin
                            state_d  = S_STEP;
                            cpu_en_d = 1'b1;
                        end
                        8'h44:   state_d = S_LATCH;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.halt || (bus.rx_done && (bus.rx_data == 8'h48))) begin
                    state_d = S_LATCH;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
            S_STEP: state_d = S_LATCH;
            S_LATCH: begin
                hdr_d      = {cnt_q, 16'(bus.pc), 16'(bus.acc[DB-1:0])};
                byte_idx_d = '0;
                word_idx_d = '0;
                dbg_own_d  = 1'b1;
`ifdef DBG_CHECKSUM_EN
                csum_d     = 8'h00;
`endif
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_data_d  = cur_byte;
                tx_start_d = 1'b1;
                byte_idx_d = byte_idx_q + 1'b1;
                // The word index advances once its low byte has gone out.
                if (in_mem && byte_idx_q[0]) word_idx_d = word_idx_q + 1'b1;
`ifdef DBG_CHECKSUM_EN
                csum_d     = csum_q ^ cur_byte;
`endif
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    if (byte_idx_q == LEN_B) begin
                        dbg_own_d = 1'b0;
                        state_d   = S_IDLE;
                    end else if (in_mem && !byte_idx_q[0]) begin
                        dm_rd_d   = 1'b1;
                        dm_addr_d = word_idx_q;
                        state_d   = S_MEMRD;
                    end else begin
                        state_d   = S_SEND;
                    end
                end
            end
            S_MEMRD:  state_d = S_MEMCAP;
            S_MEMCAP: begin
                word_d  = 16'(bus.dm_data[DB-1:0]);
                state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            word_q     <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            cpu_en_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            dm_rd_q    <= 1'b0;
            dm_addr_q  <= '0;
            dbg_own_q  <= 1'b0;
`ifdef DBG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            cpu_en_q   <= cpu_en_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            dm_rd_q    <= dm_rd_d;
            dm_addr_q  <= dm_addr_d;
            dbg_own_q  <= dbg_own_d;
`ifdef DBG_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.dm_rd    = dm_rd_q;
    assign bus.dm_addr  = dm_addr_q;
    assign bus.dbg_own  = dbg_own_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_bip_debug_unit.sv
// Bench for bip_debug_unit with DUMP_DEPTH=2. It models the UART transmitter
// and the data memory. Each expected frame is built from bench-side values and
// a bench-side model of the cycle counter.
module tb_bip_debug_unit;
  localparam int DD = 2;
`ifdef DBG_CHECKSUM_EN
  localparam int FLEN = 7 + 2 * DD;
`else
  localparam int FLEN = 6 + 2 * DD;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  bip_debug_unit_if #(.AB(11), .DB(16)) bus ();

  bip_debug_unit #(.AB(11), .DB(16), .DUMP_DEPTH(DD)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [15:0] mem [0:2047];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  int          tx_delay = 0;
  logic [15:0] model_cnt;

  // Data memory: registered read, data valid the cycle after dm_rd.
  always @(posedge clk) if (bus.dm_rd) bus.dm_data <= mem[bus.dm_addr];

  // UART transmitter: capture each byte, answer with tx_done a few cycles later.
  always @(negedge clk) begin
    bus.tx_done = 1'b0;
    if (!reset) begin
      tx_delay = 0;
    end else if (bus.tx_start) begin
      got_q.push_back(bus.tx_data);
      tx_delay = $urandom_range(2, 6);
    end else if (tx_delay > 0) begin
      tx_delay--;
      if (tx_delay == 0) begin
        bus.tx_done = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] cnt);
    logic [7:0]  b [$];
    logic [15:0] p16;
    logic [15:0] a16;
    logic [15:0] w16;
    logic [7:0]  x;
    p16 = 16'(bus.pc);
    a16 = bus.acc;
    b = {cnt[15:8], cnt[7:0], p16[15:8], p16[7:0], a16[15:8], a16[7:0]};
    for (int w = 0; w < DD; w++) begin
      w16 = mem[w];
      b.push_back(w16[15:8]);
      b.push_back(w16[7:0]);
    end
`ifdef DBG_CHECKSUM_EN
    x = 8'h00;
    foreach (b[k]) x = x ^ b[k];
    b.push_back(x);
`else
    x = 8'h00;
`endif
    foreach (b[k]) exp_q.push_back(b[k]);
  endtask

  task automatic check_frame();
    int k;
    chk("frame_len", got_q.size(), FLEN);
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk($sformatf("frame_byte%0d", k), got_q.pop_front(), exp_q.pop_front());
      k++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Issue one command and follow it to the end of its frame.
  // halt_after: raise halt once this many cpu_en cycles are seen (0 = never).
  // h_after: send 'H' once this many cpu_en cycles are seen (0 = never).
  // inject: send 'R','S',0x00 while the frame is being dumped.
  task automatic run_cmd(input logic [7:0] cmd, input int exp_en, input int halt_after,
                         input int h_after, input bit inject);
    int en_cnt;
    int both;
    int inj;
    bit seen_own;
    bit ended;
    logic [7:0] inj_byte;
    done_cnt = 0;
    en_cnt = 0;
    both = 0;
    inj = 0;
    seen_own = 1'b0;
    ended = 1'b0;
    model_cnt = (32'(model_cnt) + exp_en > 32'hFFFF) ? 16'hFFFF : model_cnt + 16'(exp_en);
    push_frame(model_cnt);
    @(negedge clk);
    bus.rx_data = cmd;
    bus.rx_done = 1'b1;
    for (int i = 0; i < 3000 && !ended; i++) begin
      @(negedge clk);
      bus.rx_done = 1'b0;
      if (bus.cpu_en) en_cnt++;
      if (bus.cpu_en && bus.dbg_own) both++;
      if (halt_after > 0 && en_cnt == halt_after) bus.halt = 1'b1;
      if (h_after > 0 && en_cnt == h_after && bus.cpu_en) begin
        bus.rx_data = 8'h48;
        bus.rx_done = 1'b1;
      end
      if (inject && bus.dbg_own && inj < 3 && (i % 5) == 0) begin
        case (inj)
          0:       inj_byte = 8'h52;
          1:       inj_byte = 8'h53;
          default: inj_byte = 8'h00;
        endcase
        bus.rx_data = inj_byte;
        bus.rx_done = 1'b1;
        inj++;
      end
      if (bus.dbg_own) begin
        seen_own = 1'b1;
      end else if (seen_own) begin
        ended = 1'b1;
        chk("tx_done_count_at_own_fall", done_cnt, FLEN);
      end
    end
    chk("frame_completed", 32'(ended), 1);
    chk("cpu_en_cycles", en_cnt, exp_en);
    chk("cpu_en_with_dbg_own", both, 0);
    check_frame();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_cpu_en"},   32'(bus.cpu_en),   0);
    chk({tag, "_dbg_own"},  32'(bus.dbg_own),  0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    chk({tag, "_tx_data"},  32'(bus.tx_data),  0);
    chk({tag, "_dm_rd"},    32'(bus.dm_rd),    0);
    chk({tag, "_dm_addr"},  32'(bus.dm_addr),  0);
    chk({tag, "_state"},    32'(dbg_state),    0);
  endtask

  initial begin
    int activity;
    bit hit;
    reset = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.halt = 1'b0;
    bus.pc = '0;
    bus.acc = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hBEEF;
    model_cnt = 16'h0000;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Dump only: no execution, CNT 0.
    bus.pc = 11'h005;
    bus.acc = 16'h1234;
    run_cmd(8'h44, 0, 0, 0, 1'b0);

    // Two single steps: CNT 1 then 2.
    bus.pc = 11'h006;
    bus.acc = 16'h00A5;
    run_cmd(8'h53, 1, 0, 0, 1'b0);
    bus.pc = 11'h7FF;
    bus.acc = 16'hFFFF;
    run_cmd(8'h53, 1, 0, 0, 1'b0);

    // Run until halt rises after 10 enabled cycles.
    bus.pc = 11'h010;
    bus.acc = 16'h8001;
    run_cmd(8'h52, 10, 10, 0, 1'b0);

    // Run while halted: no execution, CNT unchanged.
    run_cmd(8'h52, 0, 0, 0, 1'b0);

    // Step while halted: the HALT instruction is executed again for one cycle.
    run_cmd(8'h53, 1, 0, 0, 1'b0);

    // Commands sent during a dump are dropped: exactly one frame.
    bus.halt = 1'b0;
    mem[1] = 16'h5A0F;
    run_cmd(8'h44, 0, 0, 0, 1'b1);
    activity = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.dbg_own || bus.cpu_en || bus.tx_start) activity++;
    end
    chk("no_extra_frame_activity", activity, 0);
    chk("no_extra_frame_bytes", got_q.size(), 0);

    // Forced halt with 'H' after 5 enabled cycles.
    bus.acc = 16'h0F0F;
    run_cmd(8'h52, 5, 0, 5, 1'b0);

    // Reset in the middle of a frame: outputs clear without a clock edge.
    @(negedge clk);
    bus.rx_data = 8'h44;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (got_q.size() >= 3) hit = 1'b1;
    end
    chk("midframe_byte3_reached", 32'(hit), 1);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    model_cnt = 16'h0000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_no_resume", got_q.size(), 0);
    run_cmd(8'h44, 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
